spi_seq: RTL and testbench

SPI_SEQ -- requirements
Module: spi_seq

---
 rtl/spi_seq.sv | 195 +++++++++++++++++++
 tb/tb_spi_seq.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_seq.sv
// spi_seq: arbitrates the SPI register port between the CPU and a flash-read sequencer.
// Define SPI_SEQ_FAST_READ_EN for opcode 0x0B plus one dummy byte after the address.
module spi_seq #(
  parameter int         GUARD  = 128,
  parameter logic [7:0] RD_CMD = 8'h03
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  cpu_reg_addr,
  input  logic [7:0]  cpu_reg_data_in,
  output logic [7:0]  cpu_reg_data_out,
  input  logic [1:0]  cpu_reg_sel,
  input  logic        cpu_reg_read,
  input  logic        cpu_reg_write,
  output logic        cpu_stall,
  input  logic        fetch_req,
  input  logic [23:0] fetch_addr,
  input  logic [3:0]  fetch_len,
  input  logic [1:0]  fetch_sel,
  output logic        fetch_ack,
  output logic [7:0]  fetch_data,
  output logic        fetch_valid,
  output logic        fetch_done,
  output logic [2:0]  spi_reg_addr,
  output logic [7:0]  spi_reg_data_in,
  input  logic [7:0]  spi_reg_data_out,
  output logic [1:0]  spi_reg_sel,
  output logic        spi_reg_read,
  output logic        spi_reg_write,
  input  logic        spi_interrupt
);

`ifdef SPI_SEQ_FAST_READ_EN
  localparam logic [7:0] CMD_OP = 8'h0B;
`else
  localparam logic [7:0] CMD_OP = RD_CMD;
`endif
  localparam int GW = ($clog2(GUARD + 1) < 1) ? 1 : $clog2(GUARD + 1);

  typedef enum logic [1:0] {OWN_IDLE, OWN_CPU_LOCK, OWN_SEQ, OWN_GUARD} owner_t;
  typedef enum logic [2:0] {
    SQ_CMD, SQ_W, SQ_A2, SQ_A1, SQ_A0,
`ifdef SPI_SEQ_FAST_READ_EN
    SQ_DUMMY,
`endif
    SQ_DATA, SQ_RD
  } seq_t;

  owner_t        owner, owner_nxt;
  seq_t          seq, seq_nxt, ret, ret_nxt;
  logic [23:0]   cap_addr, cap_addr_nxt;
  logic [1:0]    cap_sel, cap_sel_nxt;
  logic [4:0]    remaining, remaining_nxt;
  logic [GW-1:0] guard_cnt, guard_cnt_nxt;

  logic cpu_strobe, accept, last;

  assign cpu_strobe       = cpu_reg_read | cpu_reg_write;
  assign accept           = (owner == OWN_IDLE) && fetch_req && !cpu_strobe;
  assign last             = (remaining == 5'd1);
  assign cpu_reg_data_out = spi_reg_data_out;
  assign fetch_data       = spi_reg_data_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= OWN_IDLE;
      seq       <= SQ_CMD;
      ret       <= SQ_CMD;
      cap_addr  <= '0;
      cap_sel   <= '0;
      remaining <= '0;
      guard_cnt <= '0;
    end else begin
      owner     <= owner_nxt;
      seq       <= seq_nxt;
      ret       <= ret_nxt;
      cap_addr  <= cap_addr_nxt;
      cap_sel   <= cap_sel_nxt;
      remaining <= remaining_nxt;
      guard_cnt <= guard_cnt_nxt;
    end
  end

  // Every sequencer write parks in W, remembering where to resume once the SPI core interrupts.
  always_comb begin
    owner_nxt     = owner;
    seq_nxt       = seq;
    ret_nxt       = ret;
    cap_addr_nxt  = cap_addr;
    cap_sel_nxt   = cap_sel;
    remaining_nxt = remaining;
    guard_cnt_nxt = '0;
    case (owner)
      OWN_IDLE: begin
        if (cpu_reg_write && cpu_reg_addr == 3'd0) begin
          owner_nxt = OWN_CPU_LOCK;
        end else if (accept) begin
          owner_nxt     = OWN_SEQ;
          seq_nxt       = SQ_CMD;
          cap_addr_nxt  = fetch_addr;
          cap_sel_nxt   = fetch_sel;
          remaining_nxt = (fetch_len == 4'd0) ? 5'd16 : {1'b0, fetch_len};
        end
      end
      OWN_CPU_LOCK: begin
        if (cpu_reg_read && cpu_reg_addr == 3'd0) owner_nxt = OWN_GUARD;
      end
      OWN_SEQ: begin
        case (seq)
          SQ_CMD: begin seq_nxt = SQ_W; ret_nxt = SQ_A2; end
          SQ_A2:  begin seq_nxt = SQ_W; ret_nxt = SQ_A1; end
          SQ_A1:  begin seq_nxt = SQ_W; ret_nxt = SQ_A0; end
`ifdef SPI_SEQ_FAST_READ_EN
          SQ_A0:    begin seq_nxt = SQ_W; ret_nxt = SQ_DUMMY; end
          SQ_DUMMY: begin seq_nxt = SQ_W; ret_nxt = SQ_DATA; end
`else
          SQ_A0:  begin seq_nxt = SQ_W; ret_nxt = SQ_DATA; end
`endif
          SQ_DATA: begin seq_nxt = SQ_W; ret_nxt = SQ_RD; end
          SQ_W: begin
            if (spi_interrupt) seq_nxt = ret;
          end
          SQ_RD: begin
            if (last) begin
              owner_nxt     = OWN_GUARD;
              seq_nxt       = SQ_CMD;
              remaining_nxt = '0;
            end else begin
              remaining_nxt = remaining - 5'd1;
              seq_nxt       = SQ_DATA;
            end
          end
          default: seq_nxt = SQ_CMD;
        endcase
      end
      OWN_GUARD: begin
        if (guard_cnt == GW'(GUARD - 1)) owner_nxt = OWN_IDLE;
        else guard_cnt_nxt = guard_cnt + 1'b1;
      end
      default: owner_nxt = OWN_IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held so nothing leaks before the state register clears.
  always_comb begin
    spi_reg_addr    = cpu_reg_addr;
    spi_reg_data_in = cpu_reg_data_in;
    spi_reg_sel     = cpu_reg_sel;
    spi_reg_read    = 1'b0;
    spi_reg_write   = 1'b0;
    cpu_stall       = 1'b0;
    fetch_ack       = 1'b0;
    fetch_valid     = 1'b0;
    fetch_done      = 1'b0;
    if (!reset) begin
      case (owner)
        OWN_IDLE, OWN_CPU_LOCK: begin
          spi_reg_read  = cpu_reg_read;
          spi_reg_write = cpu_reg_write;
          fetch_ack     = accept;
        end
        OWN_SEQ: begin
          cpu_stall       = cpu_strobe;
          spi_reg_sel     = cap_sel;
          spi_reg_addr    = 3'd1;
          spi_reg_data_in = 8'hFF;
          case (seq)
            SQ_CMD: begin
              spi_reg_addr    = 3'd0;
              spi_reg_data_in = CMD_OP;
              spi_reg_write   = 1'b1;
            end
            SQ_A2: begin spi_reg_data_in = cap_addr[23:16]; spi_reg_write = 1'b1; end
            SQ_A1: begin spi_reg_data_in = cap_addr[15:8];  spi_reg_write = 1'b1; end
            SQ_A0: begin spi_reg_data_in = cap_addr[7:0];   spi_reg_write = 1'b1; end
`ifdef SPI_SEQ_FAST_READ_EN
            SQ_DUMMY: spi_reg_write = 1'b1;
`endif
            SQ_DATA: spi_reg_write = 1'b1;
            SQ_RD: begin
              spi_reg_addr = last ? 3'd0 : 3'd1;
              spi_reg_read = 1'b1;
              fetch_valid  = 1'b1;
              fetch_done   = last;
            end
            default: ;
          endcase
        end
        OWN_GUARD: cpu_stall = cpu_strobe;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_seq.sv
// tb_spi_seq: directed self-checking bench for spi_seq with a small SPI core responder.
// Expectations follow SPI_SEQ_FAST_READ_EN when it is defined.
module tb_spi_seq;

`ifdef SPI_SEQ_FAST_READ_EN
  localparam logic [7:0] OP    = 8'h0B;
  localparam int         EXTRA = 1;
`else
  localparam logic [7:0] OP    = 8'h03;
  localparam int         EXTRA = 0;
`endif
  localparam int GUARD_CYC = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  cpu_reg_addr;
  logic [7:0]  cpu_reg_data_in, cpu_reg_data_out;
  logic [1:0]  cpu_reg_sel;
  logic        cpu_reg_read, cpu_reg_write, cpu_stall;
  logic        fetch_req;
  logic [23:0] fetch_addr;
  logic [3:0]  fetch_len;
  logic [1:0]  fetch_sel;
  logic        fetch_ack, fetch_valid, fetch_done;
  logic [7:0]  fetch_data;
  logic [2:0]  spi_reg_addr;
  logic [7:0]  spi_reg_data_in, spi_reg_data_out;
  logic [1:0]  spi_reg_sel;
  logic        spi_reg_read, spi_reg_write, spi_interrupt;

  int checks = 0;
  int failures = 0;

  logic [12:0] wr_q[$];
  logic [2:0]  rd_q[$];
  logic [8:0]  val_q[$];
  int          done_count = 0;
  int          rd_count = 0;
  int          irq_cnt = 0;

  spi_seq #(.GUARD(GUARD_CYC), .RD_CMD(8'h03)) dut (
    .clk(clk), .reset(reset),
    .cpu_reg_addr(cpu_reg_addr), .cpu_reg_data_in(cpu_reg_data_in),
    .cpu_reg_data_out(cpu_reg_data_out), .cpu_reg_sel(cpu_reg_sel),
    .cpu_reg_read(cpu_reg_read), .cpu_reg_write(cpu_reg_write), .cpu_stall(cpu_stall),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_len(fetch_len),
    .fetch_sel(fetch_sel), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .fetch_valid(fetch_valid), .fetch_done(fetch_done),
    .spi_reg_addr(spi_reg_addr), .spi_reg_data_in(spi_reg_data_in),
    .spi_reg_data_out(spi_reg_data_out), .spi_reg_sel(spi_reg_sel),
    .spi_reg_read(spi_reg_read), .spi_reg_write(spi_reg_write),
    .spi_interrupt(spi_interrupt)
  );

  always #5 clk = ~clk;

  // SPI core model: logs strobes mid-cycle, interrupts two cycles after each write,
  // and returns 0xA0 plus the number of reads seen so far as read data.
  initial begin
    spi_interrupt    = 1'b0;
    spi_reg_data_out = 8'hA0;
    forever begin
      @(negedge clk);
      if (spi_reg_write) begin
        wr_q.push_back({spi_reg_sel, spi_reg_addr, spi_reg_data_in});
        irq_cnt = 2;
      end
      if (spi_reg_read) begin
        rd_q.push_back(spi_reg_addr);
        rd_count++;
      end
      if (fetch_valid) val_q.push_back({fetch_done, fetch_data});
      if (fetch_done) done_count++;
      @(posedge clk);
      #1;
      spi_reg_data_out = 8'hA0 + 8'(rd_count);
      spi_interrupt = 1'b0;
      if (irq_cnt > 0) begin
        irq_cnt--;
        if (irq_cnt == 0) spi_interrupt = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fetch(input logic [23:0] a, input logic [3:0] l, input logic [1:0] s,
                             output bit acked);
    acked = 1'b0;
    fetch_addr = a; fetch_len = l; fetch_sel = s; fetch_req = 1'b1;
    for (int n = 0; n < 400; n++) begin
      #1;
      if (fetch_ack) begin acked = 1'b1; break; end
      tick();
    end
    if (acked) tick();
    fetch_req = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int start;
    int n;
    start = done_count;
    n = 0;
    while (done_count == start && n < 600) begin tick(); n++; end
    ok = (done_count != start);
    repeat (GUARD_CYC + 4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fetch_req = 1'b1; cpu_reg_write = 1'b1; cpu_reg_addr = 3'd0;
    tick(); tick();
    checks++;
    if ({fetch_ack, fetch_valid, fetch_done, cpu_stall, spi_reg_read, spi_reg_write} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got %b expected 000000",
               {fetch_ack, fetch_valid, fetch_done, cpu_stall, spi_reg_read, spi_reg_write});
    end
    reset = 1'b0; fetch_req = 1'b0; cpu_reg_write = 1'b0;
    cpu_reg_read = 1'b1; cpu_reg_addr = 3'd5;
    #1;
    checks++;
    if ({spi_reg_read, spi_reg_addr, cpu_stall} !== {1'b1, 3'd5, 1'b0}) begin
      failures++;
      $display("[TB] FAIL idle_passthrough got rd=%b addr=%0d stall=%b expected rd=1 addr=5 stall=0",
               spi_reg_read, spi_reg_addr, cpu_stall);
    end
    checks++;
    if (cpu_reg_data_out !== spi_reg_data_out) begin
      failures++;
      $display("[TB] FAIL cpu_data_out got %h expected %h", cpu_reg_data_out, spi_reg_data_out);
    end
    tick();
    cpu_reg_read = 1'b0;
    tick();
  endtask

  task automatic test_basic_fetch();
    logic [12:0] exp_wr[$];
    int wb, rb, vb, rdb;
    bit acked, ok;
    wb = wr_q.size(); rb = rd_q.size(); vb = val_q.size(); rdb = rd_count;
    exp_wr = '{{2'd0, 3'd0, OP}, {2'd0, 3'd1, 8'h01}, {2'd0, 3'd1, 8'h23}, {2'd0, 3'd1, 8'h45}};
    if (EXTRA == 1) exp_wr.push_back({2'd0, 3'd1, 8'hFF});
    exp_wr.push_back({2'd0, 3'd1, 8'hFF});
    exp_wr.push_back({2'd0, 3'd1, 8'hFF});
    start_fetch(24'h012345, 4'd2, 2'd0, acked);
    wait_done(ok);
    checks++;
    if (!(acked && ok)) begin
      failures++;
      $display("[TB] FAIL basic_complete got ack=%b done=%b expected 1 1", acked, ok);
    end
    checks++;
    if (wr_q.size() - wb !== exp_wr.size()) begin
      failures++;
      $display("[TB] FAIL basic_wr_count got %0d expected %0d", wr_q.size() - wb, exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size(); i++) begin
      checks++;
      if (wr_q[wb + i] !== exp_wr[i]) begin
        failures++;
        $display("[TB] FAIL basic_wr[%0d] got %h expected %h", i, wr_q[wb + i], exp_wr[i]);
      end
    end
    checks++;
    if ({rd_q.size() - rb, rd_q[rb], rd_q[rb + 1]} !== {32'd2, 3'd1, 3'd0}) begin
      failures++;
      $display("[TB] FAIL basic_reads got n=%0d a0=%0d a1=%0d expected n=2 a0=1 a1=0",
               rd_q.size() - rb, rd_q[rb], rd_q[rb + 1]);
    end
    checks++;
    if ({val_q.size() - vb, val_q[vb], val_q[vb + 1]} !==
        {32'd2, 1'b0, 8'hA0 + 8'(rdb), 1'b1, 8'hA1 + 8'(rdb)}) begin
      failures++;
      $display("[TB] FAIL basic_valid got n=%0d v0=%h v1=%h expected n=2 v0=%h v1=%h",
               val_q.size() - vb, val_q[vb], val_q[vb + 1],
               {1'b0, 8'hA0 + 8'(rdb)}, {1'b1, 8'hA1 + 8'(rdb)});
    end
  endtask

  task automatic test_sel3();
    int wb, vb, bad;
    bit acked, ok;
    wb = wr_q.size(); vb = val_q.size();
    start_fetch(24'hABCDEF, 4'd1, 2'd3, acked);
    wait_done(ok);
    bad = 0;
    for (int i = wb; i < wr_q.size(); i++) if (wr_q[i][12:11] !== 2'd3) bad++;
    checks++;
    if ({wr_q.size() - wb, bad} !== {32'(5 + EXTRA), 32'd0}) begin
      failures++;
      $display("[TB] FAIL sel3_writes got n=%0d badsel=%0d expected n=%0d badsel=0",
               wr_q.size() - wb, bad, 5 + EXTRA);
    end
    checks++;
    if ({val_q.size() - vb, val_q[vb][8]} !== {32'd1, 1'b1}) begin
      failures++;
      $display("[TB] FAIL sel3_valid got n=%0d done=%b expected n=1 done=1",
               val_q.size() - vb, val_q[vb][8]);
    end
  endtask

  task automatic test_len16();
    int wb, vb, db, rb, bad;
    bit acked, ok;
    wb = wr_q.size(); vb = val_q.size(); db = done_count; rb = rd_q.size();
    start_fetch(24'h000100, 4'd0, 2'd2, acked);
    wait_done(ok);
    checks++;
    if ({val_q.size() - vb, wr_q.size() - wb, done_count - db} !== {32'd16, 32'(20 + EXTRA), 32'd1}) begin
      failures++;
      $display("[TB] FAIL len16_counts got valid=%0d writes=%0d done=%0d expected 16 %0d 1",
               val_q.size() - vb, wr_q.size() - wb, done_count - db, 20 + EXTRA);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (rd_q[rb + i] !== ((i == 15) ? 3'd0 : 3'd1)) bad++;
      if (val_q[vb + i][8] !== (i == 15)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL len16_read_pattern got %0d bad entries expected 0", bad);
    end
  endtask

  task automatic test_cpu_tie();
    int n;
    bit ok;
    cpu_reg_write = 1'b1; cpu_reg_addr = 3'd0; cpu_reg_data_in = 8'h55; cpu_reg_sel = 2'd0;
    fetch_req = 1'b1; fetch_addr = 24'h000200; fetch_len = 4'd1; fetch_sel = 2'd0;
    #1;
    checks++;
    if ({spi_reg_write, spi_reg_data_in, fetch_ack} !== {1'b1, 8'h55, 1'b0}) begin
      failures++;
      $display("[TB] FAIL tie_cpu_wins got wr=%b data=%h ack=%b expected 1 55 0",
               spi_reg_write, spi_reg_data_in, fetch_ack);
    end
    tick();
    cpu_reg_write = 1'b0;
    tick();
    cpu_reg_read = 1'b1;
    #1;
    checks++;
    if ({spi_reg_read, fetch_ack, cpu_stall} !== {1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL lock_read got rd=%b ack=%b stall=%b expected 1 0 0",
               spi_reg_read, fetch_ack, cpu_stall);
    end
    tick();
    cpu_reg_read = 1'b0;
    n = 1;
    while (n < 300) begin
      #1;
      if (fetch_ack) break;
      tick();
      n++;
    end
    checks++;
    if (n !== GUARD_CYC + 1) begin
      failures++;
      $display("[TB] FAIL tie_ack_delay got %0d cycles expected %0d", n, GUARD_CYC + 1);
    end
    tick();
    fetch_req = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL tie_fetch_done got 0 expected 1");
    end
  endtask

  task automatic test_cpu_stall();
    int wb, n, stalls;
    bit acked, fwd;
    wb = wr_q.size();
    start_fetch(24'h000010, 4'd1, 2'd1, acked);
    cpu_reg_write = 1'b1; cpu_reg_addr = 3'd2; cpu_reg_data_in = 8'h77; cpu_reg_sel = 2'd0;
    stalls = 0; fwd = 1'b0;
    for (n = 0; n < 400; n++) begin
      #1;
      if (spi_reg_write && spi_reg_data_in == 8'h77 && !cpu_stall) begin fwd = 1'b1; break; end
      if (cpu_stall) stalls++;
      tick();
    end
    tick();
    cpu_reg_write = 1'b0;
    checks++;
    if ({fwd, stalls} !== {1'b1, 32'(144 + 3 * EXTRA)}) begin
      failures++;
      $display("[TB] FAIL stall_cycles got fwd=%b stalls=%0d expected fwd=1 stalls=%0d",
               fwd, stalls, 144 + 3 * EXTRA);
    end
    checks++;
    if ({wr_q.size() - wb, wr_q[wr_q.size() - 1]} !== {32'(6 + EXTRA), 2'd0, 3'd2, 8'h77}) begin
      failures++;
      $display("[TB] FAIL stall_writes got n=%0d last=%h expected n=%0d last=%h",
               wr_q.size() - wb, wr_q[wr_q.size() - 1], 6 + EXTRA, {2'd0, 3'd2, 8'h77});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int wb, db, n;
    bit acked, ok;
    wb = wr_q.size(); db = done_count;
    start_fetch(24'h111111, 4'd4, 2'd0, acked);
    n = 0;
    while (wr_q.size() < wb + 3 && n < 100) begin tick(); n++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({fetch_ack, fetch_valid, fetch_done, cpu_stall, spi_reg_read, spi_reg_write} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs got %b expected 000000",
               {fetch_ack, fetch_valid, fetch_done, cpu_stall, spi_reg_read, spi_reg_write});
    end
    fetch_req = 1'b1; fetch_addr = 24'h222222; fetch_len = 4'd1; fetch_sel = 2'd0;
    #1;
    checks++;
    if ({fetch_ack, done_count - db} !== {1'b1, 32'd0}) begin
      failures++;
      $display("[TB] FAIL midreset_reack got ack=%b done=%0d expected 1 0", fetch_ack, done_count - db);
    end
    tick();
    fetch_req = 1'b0;
    wait_done(ok);
    checks++;
    if ({ok, wr_q.size() - wb, wr_q[wb + 3]} !== {1'b1, 32'(8 + EXTRA), 2'd0, 3'd0, OP}) begin
      failures++;
      $display("[TB] FAIL midreset_refetch got done=%b n=%0d first=%h expected 1 %0d %h",
               ok, wr_q.size() - wb, wr_q[wb + 3], 8 + EXTRA, {2'd0, 3'd0, OP});
    end
  endtask

  initial begin
    reset = 1'b1;
    cpu_reg_addr = '0; cpu_reg_data_in = '0; cpu_reg_sel = '0;
    cpu_reg_read = 1'b0; cpu_reg_write = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0; fetch_len = '0; fetch_sel = '0;
    test_reset();
    test_basic_fetch();
    test_sel3();
    test_len16();
    test_cpu_tie();
    test_cpu_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
